// File: rtl/aes_decrypt_iter_ctrl.sv
// Iterative AES inverse cipher: one shared inverse-round datapath stepped Nr-1 times,
// with key schedule, round-key select and valid/ready handshakes on both sides.
module aes_decrypt_iter_ctrl #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [N-1:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [3:0]   round_idx
);

  // state | meaning
  // IDLE  | waiting for a ciphertext/key, in_ready high
  // INIT  | initial addRoundKey with rk[Nr]
  // ROUND | one full inverse round per cycle, rk[Nr-1] down to rk[1]
  // FINAL | last round without invMixColumns, rk[0]
  // DONE  | plaintext held until the sink accepts it
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] INIT  = 3'd1;
  localparam logic [2:0] ROUND = 3'd2;
  localparam logic [2:0] FINAL = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int SW = 128 * (Nr + 1);

  logic [2:0]     fsm;
  logic [127:0]   blk;
  logic [127:0]   ct_q;
  logic [N-1:0]   key_q;
  logic [SW-1:0]  sched;
  logic [127:0]   rk_sel;
  logic [127:0]   rk_last;
  logic [127:0]   ark;
  logic [127:0]   mixed;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(a, a);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [SW-1:0] key_expansion(input logic [N-1:0] key);
    logic [31:0]   w [0:4*(Nr+1)-1];
    logic [31:0]   tmp;
    logic [7:0]    rc;
    logic [SW-1:0] s;
    rc = 8'h01;
    for (int i = 0; i < Nk; i++) w[i] = key[N-1-32*i -: 32];
    for (int i = Nk; i < 4 * (Nr + 1); i++) begin
      tmp = w[i-1];
      if (i % Nk == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xtime(rc);
      end else if (Nk > 6 && i % Nk == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-Nk] ^ tmp;
    end
    for (int r = 0; r <= Nr; r++) s[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  // Byte i of the block sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign sched   = key_expansion(key_q);
  assign rk_last = sched[128*Nr +: 128];

  // round_idx still reads 1 during FINAL, so the last stage forces rk[0]
  assign rk_sel  = (fsm == FINAL) ? sched[127:0] : sched[{round_idx, 7'd0} +: 128];
  assign ark     = inv_shift_sub(blk) ^ rk_sel;
  assign mixed   = inv_mix(ark);

  assign in_ready = (fsm == IDLE);
  assign busy     = (fsm != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      blk       <= '0;
      ct_q      <= '0;
      key_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      round_idx <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            ct_q  <= in_data;
            key_q <= in_key;
            fsm   <= INIT;
          end
        end
        INIT: begin
          blk       <= ct_q ^ rk_last;
          round_idx <= 4'(Nr - 1);
          fsm       <= ROUND;
        end
        ROUND: begin
          blk <= mixed;
          if (round_idx == 4'd1) fsm <= FINAL;
          else round_idx <= round_idx - 4'd1;
        end
        FINAL: begin
          out_data  <= ark;
          out_valid <= 1'b1;
          round_idx <= '0;
          fsm       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_iter_ctrl.sv
// Directed bench for the iterative AES decryptor: AES-128/192/256 instances
// driven from a vector table plus backpressure, busy-ignore and mid-op reset sequences.
module tb_aes_decrypt_iter_ctrl;

  typedef struct {
    int unsigned  sel;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int unsigned  nr;
  } vec_t;

  localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid_a [3];
  logic         in_ready_a [3];
  logic         out_valid_a [3];
  logic         busy_a [3];
  logic [127:0] out_data_a [3];
  logic [3:0]   ridx_a [3];
  logic [127:0] in_data;
  logic [255:0] in_key;
  logic         out_ready;

  int n_pass = 0;
  int n_total = 0;
  vec_t vecs [5];

  always #5 clk = ~clk;

  aes_decrypt_iter_ctrl #(.N(128), .Nr(10), .Nk(4)) d128 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .in_data(in_data), .in_key(in_key[255:128]), .out_valid(out_valid_a[0]),
    .out_ready(out_ready), .out_data(out_data_a[0]), .busy(busy_a[0]), .round_idx(ridx_a[0]));

  aes_decrypt_iter_ctrl #(.N(192), .Nr(12), .Nk(6)) d192 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .in_data(in_data), .in_key(in_key[255:64]), .out_valid(out_valid_a[1]),
    .out_ready(out_ready), .out_data(out_data_a[1]), .busy(busy_a[1]), .round_idx(ridx_a[1]));

  aes_decrypt_iter_ctrl #(.N(256), .Nr(14), .Nk(8)) d256 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid_a[2]),
    .out_ready(out_ready), .out_data(out_data_a[2]), .busy(busy_a[2]), .round_idx(ridx_a[2]));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic accept(input int sel, input logic [255:0] key, input logic [127:0] ct);
    @(negedge clk);
    in_key = key;
    in_data = ct;
    in_valid_a[sel] = 1'b1;
    chk("in_ready_idle", 128'(in_ready_a[sel]), 128'd1);
    @(posedge clk);
    #1;
    in_valid_a[sel] = 1'b0;
    chk("busy_after_accept", 128'(busy_a[sel]), 128'd1);
    chk("in_ready_after_accept", 128'(in_ready_a[sel]), 128'd0);
  endtask

  // pre = clock edges already elapsed since the accept edge
  task automatic wait_out(input int sel, input int nr, input int pre);
    int cyc;
    cyc = pre;
    while (!out_valid_a[sel] && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) chk("round_idx_after_init", 128'(ridx_a[sel]), 128'(nr - 1));
    end
    chk("latency", 128'(cyc), 128'(nr + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, KEY_C1, CT_C1, PT_C, 10};
    vecs[1] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, 10};
    vecs[2] = '{0, 256'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 10};
    vecs[3] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT_C, 12};
    vecs[4] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h8ea2b7ca516745bfeafc49904b496089, PT_C, 14};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) in_valid_a[i] = 1'b0;
    in_data = '0;
    in_key = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", 128'(in_ready_a[i]), 128'd1);
      chk("rst_out_valid", 128'(out_valid_a[i]), 128'd0);
      chk("rst_busy", 128'(busy_a[i]), 128'd0);
      chk("rst_out_data", out_data_a[i], 128'd0);
      chk("rst_round_idx", 128'(ridx_a[i]), 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Table: full decrypt per vector with the sink always ready
    for (int k = 0; k < 5; k++) begin
      accept(int'(vecs[k].sel), vecs[k].key, vecs[k].ct);
      wait_out(int'(vecs[k].sel), int'(vecs[k].nr), 0);
      chk("plaintext", out_data_a[vecs[k].sel], vecs[k].pt);
      chk("round_idx_done", 128'(ridx_a[vecs[k].sel]), 128'd0);
      @(posedge clk);
      #1;
      chk("out_valid_dropped", 128'(out_valid_a[vecs[k].sel]), 128'd0);
      chk("in_ready_back", 128'(in_ready_a[vecs[k].sel]), 128'd1);
      chk("out_data_held", out_data_a[vecs[k].sel], vecs[k].pt);
    end

    // Backpressure: output held for 20 cycles, then a single out_ready pulse
    out_ready = 1'b0;
    accept(0, KEY_C1, CT_C1);
    wait_out(0, 10, 0);
    chk("bp_plaintext", out_data_a[0], PT_C);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 128'(out_valid_a[0]), 128'd1);
      chk("bp_out_data", out_data_a[0], PT_C);
      chk("bp_in_ready", 128'(in_ready_a[0]), 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_valid", 128'(out_valid_a[0]), 128'd0);
    chk("bp_release_ready", 128'(in_ready_a[0]), 128'd1);
    chk("bp_release_busy", 128'(busy_a[0]), 128'd0);
    out_ready = 1'b1;

    // Busy-ignore: new key/data and an in_valid pulse while in ROUND
    begin
      int seen;
      accept(0, KEY_C1, CT_C1);
      repeat (4) @(posedge clk);
      #1;
      in_key = {256{1'b1}};
      in_data = 128'hdeadbeef_cafef00d_01234567_89abcdef;
      in_valid_a[0] = 1'b1;
      @(posedge clk);
      #1;
      in_valid_a[0] = 1'b0;
      wait_out(0, 10, 5);
      chk("ignore_plaintext", out_data_a[0], PT_C);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
        @(posedge clk);
        #1;
        if (out_valid_a[0] || busy_a[0]) seen++;
      end
      chk("ignore_no_second_output", 128'(seen), 128'd0);
    end

    // Reset during ROUND cycle 5 aborts immediately, then a normal transaction
    accept(0, KEY_C1, CT_C1);
    repeat (5) @(posedge clk);
    #1;
    chk("pre_reset_busy", 128'(busy_a[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid_a[0]), 128'd0);
    chk("midrst_busy", 128'(busy_a[0]), 128'd0);
    chk("midrst_in_ready", 128'(in_ready_a[0]), 128'd1);
    chk("midrst_round_idx", 128'(ridx_a[0]), 128'd0);
    chk("midrst_out_data", out_data_a[0], 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    accept(0, KEY_C1, CT_C1);
    wait_out(0, 10, 0);
    chk("post_reset_plaintext", out_data_a[0], PT_C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
